// File: rtl/uart_pkg.sv
// Shared UART framing definitions, reused by the RX frame controller and the TX-side framer.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } frame_state_e;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam int         PAYLOAD_LEN    = 4;
  localparam int         PAYLOAD_W      = PAYLOAD_LEN * 8;

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and saturates at TIMEOUT_CYC-1.
module frame_timer #(
  parameter int TIMEOUT_CYC = 208333
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMR_W-1:0] r_cnt;

  assign o_expired = (r_cnt == TMR_W'(TIMEOUT_CYC - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Receive-side frame controller: hunts for HEADER, collects four payload bytes, checks the XOR byte
// and presents the frame with a valid/ready hold, flagging checksum, timeout and overrun errors.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] HEADER      = DEFAULT_HEADER,
  parameter int         TIMEOUT_CYC = 208333
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_done,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_frame_ready,
  output logic                 o_frame_valid,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic                 o_err_chk,
  output logic                 o_err_timeout,
  output logic                 o_err_overrun,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(PAYLOAD_LEN);

  frame_state_e         r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [7:0]           r_xor;
  logic [PAYLOAD_W-1:0] r_buf;
  logic [PAYLOAD_W-1:0] r_payload;
  logic                 r_frame_valid;
  logic                 r_err_chk;
  logic                 r_err_timeout;
  logic                 r_err_overrun;
  logic                 w_expired;
  logic                 w_timer_clr;
  logic                 w_timer_en;

  assign w_timer_clr = i_rx_done || (r_state == ST_HUNT);
  assign w_timer_en  = (r_state != ST_HUNT);

  frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clr    (w_timer_clr),
    .i_en     (w_timer_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_HUNT;
      r_cnt         <= '0;
      r_xor         <= '0;
      r_buf         <= '0;
      r_payload     <= '0;
      r_frame_valid <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_err_chk     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;

      // NOTE: the last non-blocking assignment wins, so a reload in CHECK overrides this clear.
      if (r_frame_valid && i_frame_ready) begin
        r_frame_valid <= 1'b0;
      end

      unique case (r_state)
        ST_HUNT: begin
          if (i_rx_done && (i_rx_data == HEADER)) begin
            r_state <= ST_PAYLOAD;
            r_cnt   <= '0;
            r_xor   <= '0;
          end
        end

        ST_PAYLOAD: begin
          if (i_rx_done) begin
            r_buf <= {r_buf[PAYLOAD_W-9:0], i_rx_data};
            r_xor <= r_xor ^ i_rx_data;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(PAYLOAD_LEN - 1)) begin
              r_state <= ST_CHECK;
            end
          end else if (w_expired) begin
            r_state       <= ST_HUNT;
            r_err_timeout <= 1'b1;
          end
        end

        ST_CHECK: begin
          if (i_rx_done) begin
            r_state <= ST_HUNT;
            if (i_rx_data != r_xor) begin
              r_err_chk <= 1'b1;
            end else if (!r_frame_valid || i_frame_ready) begin
              r_payload     <= r_buf;
              r_frame_valid <= 1'b1;
            end else begin
              r_err_overrun <= 1'b1;
            end
          end else if (w_expired) begin
            r_state       <= ST_HUNT;
            r_err_timeout <= 1'b1;
          end
        end

        default: r_state <= ST_HUNT;
      endcase
    end
  end

  assign o_frame_valid = r_frame_valid;
  assign o_payload     = r_payload;
  assign o_err_chk     = r_err_chk;
  assign o_err_timeout = r_err_timeout;
  assign o_err_overrun = r_err_overrun;
  assign o_busy        = (r_state != ST_HUNT);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: a byte-level frame model checked every cycle, plus literal spot checks.
module tb_uart_frame_ctrl;

  localparam int         TMO = 20;
  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        frame_ready;
  logic        frame_valid;
  logic [31:0] payload;
  logic        err_chk;
  logic        err_timeout;
  logic        err_overrun;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .HEADER     (HDR),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .i_frame_ready(frame_ready),
    .o_frame_valid(frame_valid),
    .o_payload    (payload),
    .o_err_chk    (err_chk),
    .o_err_timeout(err_timeout),
    .o_err_overrun(err_overrun),
    .o_busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a list of bytes seen since the header, and idle cycles since the last byte.
  logic [7:0]  m_q[$];
  bit          m_in_frame;
  int          m_idle;
  logic        e_valid, e_chk, e_to, e_ov;
  logic [31:0] e_payload;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_in_frame = 0;
      m_idle     = 0;
      e_valid    = 0;
      e_payload  = '0;
      e_chk      = 0;
      e_to       = 0;
      e_ov       = 0;
    end else begin
      logic held;
      held  = e_valid;
      e_chk = 0;
      e_to  = 0;
      e_ov  = 0;
      if (held && frame_ready) e_valid = 0;
      if (rx_done) begin
        m_idle = 0;
        if (!m_in_frame) begin
          if (rx_data == HDR) begin
            m_in_frame = 1;
            m_q.delete();
          end
        end else if (m_q.size() < 4) begin
          m_q.push_back(rx_data);
        end else begin
          m_in_frame = 0;
          if (rx_data != (m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3])) begin
            e_chk = 1;
          end else if (!held || frame_ready) begin
            e_valid   = 1;
            e_payload = {m_q[0], m_q[1], m_q[2], m_q[3]};
          end else begin
            e_ov = 1;
          end
        end
      end else if (m_in_frame) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_in_frame = 0;
          e_to       = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid",   {31'd0, frame_valid}, {31'd0, e_valid});
      check("payload", payload, e_payload);
      check("err_chk", {31'd0, err_chk}, {31'd0, e_chk});
      check("err_to",  {31'd0, err_timeout}, {31'd0, e_to});
      check("err_ov",  {31'd0, err_overrun}, {31'd0, e_ov});
      check("busy",    {31'd0, busy}, {31'd0, m_in_frame});
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    @(negedge clk);
    rx_done     = 1'b1;
    rx_data     = b;
    frame_ready = rdy;
    @(negedge clk);
    rx_done     = 1'b0;
    frame_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] c,
                            input logic rdy_on_chk);
    send_byte(h, 1'b0);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    send_byte(b3, 1'b0);
    send_byte(c, rdy_on_chk);
  endtask

  task automatic consume();
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    check("consumed_valid", {31'd0, frame_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    rx_done     = 1'b0;
    rx_data     = '0;
    frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid",   {31'd0, frame_valid}, 32'd0);
    check("rst_payload", payload, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_errs",    {29'd0, err_chk, err_timeout, err_overrun}, 32'd0);
    rst_n = 1'b1;

    // Good frame, then held while not ready.
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 1'b0);
    check("good_valid",   {31'd0, frame_valid}, 32'd1);
    check("good_payload", payload, 32'h1122_3344);
    check("good_errs",    {29'd0, err_chk, err_timeout, err_overrun}, 32'd0);
    repeat (3) @(negedge clk);
    check("held_payload", payload, 32'h1122_3344);
    consume();

    // Checksum mismatch: 01^02^03^04 = 04.
    send_frame(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 1'b0);
    check("chk_pulse", {31'd0, err_chk}, 32'd1);
    check("chk_valid", {31'd0, frame_valid}, 32'd0);
    check("chk_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("chk_pulse_end", {31'd0, err_chk}, 32'd0);

    // Timeout after the first payload byte.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (TMO - 1) @(negedge clk);
    check("to_early", {31'd0, err_timeout}, 32'd0);
    @(negedge clk);
    check("to_pulse", {31'd0, err_timeout}, 32'd1);
    check("to_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("to_pulse_end", {31'd0, err_timeout}, 32'd0);
    send_frame(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check("zero_valid",   {31'd0, frame_valid}, 32'd1);
    check("zero_payload", payload, 32'd0);
    consume();

    // A byte landing on the expiry cycle beats the timeout.
    send_byte(8'hA5, 1'b0);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h5A, 1'b0);
    check("race_valid",   {31'd0, frame_valid}, 32'd1);
    check("race_payload", payload, 32'h5A01_0203);
    consume();

    // Overrun while held, then reload with ready on the checksum strobe.
    send_frame(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 1'b0);
    check("ov1_payload", payload, 32'h0102_0304);
    send_frame(8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 1'b0);
    check("ov_pulse",   {31'd0, err_overrun}, 32'd1);
    check("ov_payload", payload, 32'h0102_0304);
    check("ov_valid",   {31'd0, frame_valid}, 32'd1);
    send_frame(8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 1'b1);
    check("reload_payload", payload, 32'hAABB_CCDD);
    check("reload_ov",      {31'd0, err_overrun}, 32'd0);
    check("reload_valid",   {31'd0, frame_valid}, 32'd1);
    consume();

    // Garbage, then header bytes as data; four equal bytes XOR to 00.
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    check("garbage_busy", {31'd0, busy}, 32'd0);
    send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 1'b0);
    check("hdr_data_payload", payload, 32'hA5A5_A5A5);
    check("hdr_data_valid",   {31'd0, frame_valid}, 32'd1);
    consume();

    // Reset mid-frame, then a fresh frame.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, frame_valid}, 32'd0);
    check("mid_rst_errs",  {29'd0, err_chk, err_timeout, err_overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h33, 1'b0);
    send_frame(8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22, 1'b0);
    check("post_rst_payload", payload, 32'hDEAD_BEEF);
    check("post_rst_valid",   {31'd0, frame_valid}, 32'd1);
    consume();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
